ks_sum_stage: RTL and testbench

Pipelined sum stage of the 16-bit Kogge-Stone adder. It sits directly downstream of the last prefix array (span 8). It consumes the final group generates together with the first-level propagates and the carry-in. It forms the sum, carry-out and optional status flags, and presents them through a registered valid/ready output with a 2-entry skid buffer, so back-pressure never stalls the prefix tree combinationally.

---
 rtl/ks_sum_stage.sv | 129 ++++++++++++
 tb/tb_ks_sum_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ks_sum_stage.sv
// Final sum stage of the 16-bit Kogge-Stone adder with registered valid/ready output and 2-entry skid buffer.
// Optional overflow/zero flags are enabled by defining KS_SUM_FLAGS_EN.
module ks_sum_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_Pk,
    input  logic [WIDTH-1:0] in_Gk,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

`ifdef KS_SUM_FLAGS_EN
    localparam int EW = WIDTH + 3;
`else
    localparam int EW = WIDTH + 1;
`endif

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [EW-1:0]    main_q;
    logic [EW-1:0]    skid_q;
    logic [EW-1:0]    entry_c;
    logic [WIDTH-1:0] sum_c;
    logic             in_fire;
    logic             load_main;
    logic             load_skid;
    logic             skid_to_main;

    // Carry into bit i is the group generate of bit i-1; bit 0 takes the adder carry-in.
    always_comb begin
        sum_c = in_Pk ^ {in_Gk[WIDTH-2:0], in_cin};
`ifdef KS_SUM_FLAGS_EN
        entry_c = {sum_c, in_Gk[WIDTH-1], in_Gk[WIDTH-1] ^ in_Gk[WIDTH-2], ~|sum_c};
`else
        entry_c = {sum_c, in_Gk[WIDTH-1]};
`endif
    end

    // Handshake decoded from the state register only, so out_ready never reaches in_ready.
    assign in_ready  = (state_q == EMPTY) || (state_q == ONE);
    assign out_valid = (state_q == ONE) || (state_q == TWO);
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_ready) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_ready) begin
                    skid_to_main = 1'b1;
                    state_d      = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main register feeds the outputs; it only changes when its word is consumed or it was empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (load_main) begin
            main_q <= entry_c;
        end else if (skid_to_main) begin
            main_q <= skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (load_skid) begin
            skid_q <= entry_c;
        end
    end

    assign out_sum = main_q[EW-1 -: WIDTH];
`ifdef KS_SUM_FLAGS_EN
    assign out_cout = main_q[2];
    assign out_ovf  = main_q[1];
    assign out_zero = main_q[0];
`else
    assign out_cout = main_q[0];
    assign out_ovf  = 1'b0;
    assign out_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ks_sum_stage.sv
// Self-checking bench for ks_sum_stage: directed vectors plus a FIFO scoreboard fed by an adder reference model.
// Expected flag values follow KS_SUM_FLAGS_EN in the same way as the design.
module tb_ks_sum_stage;

    localparam int WIDTH = 16;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_Pk;
    logic [WIDTH-1:0] in_Gk;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    int   tests_run;
    int   tests_failed;
    int   results_seen;
    int   accepts;
    exp_t exp_q[$];

    ks_sum_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_Pk     (in_Pk),
        .in_Gk     (in_Gk),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Ripple-carry model of the upstream prefix tree: G[i] is the carry out of bit i.
    function automatic logic [31:0] makePG(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] p;
        logic [15:0] g;
        logic        c;
        c = cin;
        for (int i = 0; i < 16; i++) begin
            p[i] = a[i] ^ b[i];
            g[i] = (a[i] & b[i]) | (p[i] & c);
            c    = g[i];
        end
        return {g, p};
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        exp_t        e;
        logic [16:0] t;
        t = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.sum  = t[15:0];
        e.cout = t[16];
`ifdef KS_SUM_FLAGS_EN
        e.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        e.zero = (t[15:0] == 16'h0000);
`else
        e.ovf  = 1'b0;
        e.zero = 1'b0;
`endif
        return e;
    endfunction

    task automatic verifyState();
        checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
        if (out_valid && exp_q.size() != 0) begin
            checkOutput("sb_sum", {16'd0, out_sum}, {16'd0, exp_q[0].sum});
            checkOutput("sb_cout", {31'd0, out_cout}, {31'd0, exp_q[0].cout});
            checkOutput("sb_ovf", {31'd0, out_ovf}, {31'd0, exp_q[0].ovf});
            checkOutput("sb_zero", {31'd0, out_zero}, {31'd0, exp_q[0].zero});
        end
    endtask

    // Called at a falling edge: drives one cycle of inputs, updates the scoreboard, then checks at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic rdy);
        logic [31:0] pg;
        pg        = makePG(a, b, cin);
        in_valid  = v;
        in_Pk     = pg[15:0];
        in_Gk     = pg[31:16];
        in_cin    = cin;
        out_ready = rdy;
        if (out_valid && rdy && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            results_seen++;
        end
        if (v && in_ready) begin
            exp_q.push_back(model(a, b, cin));
            accepts++;
        end
        @(posedge clk);
        @(negedge clk);
        verifyState();
    endtask

    initial begin
        int          r0;
        int          a0;
        logic [31:0] ra;
        logic [31:0] rb;
        tests_run    = 0;
        tests_failed = 0;
        results_seen = 0;
        accepts      = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_Pk        = '0;
        in_Gk        = '0;
        in_cin       = 1'b0;
        out_ready    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_sum", {16'd0, out_sum}, 32'd0);
        checkOutput("rst_cout", {31'd0, out_cout}, 32'd0);
        checkOutput("rst_ovf", {31'd0, out_ovf}, 32'd0);
        checkOutput("rst_zero", {31'd0, out_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Wrap to zero
        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        checkOutput("wrap_sum", {16'd0, out_sum}, 32'h0000);
        checkOutput("wrap_cout", {31'd0, out_cout}, 32'd1);
        checkOutput("wrap_ovf", {31'd0, out_ovf}, 32'd0);
`ifdef KS_SUM_FLAGS_EN
        checkOutput("wrap_zero", {31'd0, out_zero}, 32'd1);
`else
        checkOutput("wrap_zero", {31'd0, out_zero}, 32'd0);
`endif

        // Signed overflow, back-to-back with the previous word
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
        checkOutput("ovf_sum", {16'd0, out_sum}, 32'h8000);
        checkOutput("ovf_cout", {31'd0, out_cout}, 32'd0);
`ifdef KS_SUM_FLAGS_EN
        checkOutput("ovf_ovf", {31'd0, out_ovf}, 32'd1);
`else
        checkOutput("ovf_ovf", {31'd0, out_ovf}, 32'd0);
`endif
        checkOutput("ovf_zero", {31'd0, out_zero}, 32'd0);

        // Carry-in
        applyStimulus(1'b1, 16'h1234, 16'h0F0F, 1'b1, 1'b1);
        checkOutput("cin_sum", {16'd0, out_sum}, 32'h2144);
        checkOutput("cin_cout", {31'd0, out_cout}, 32'd0);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Back-pressure: W0, W1 accepted, W2 held until the skid drains
        applyStimulus(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0);
        checkOutput("bp_w0_sum", {16'd0, out_sum}, 32'h0003);
        applyStimulus(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0);
        checkOutput("bp_hold_sum", {16'd0, out_sum}, 32'h0003);
        applyStimulus(1'b1, 16'h1000, 16'h2000, 1'b0, 1'b0);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_still_w0", {16'd0, out_sum}, 32'h0003);
        applyStimulus(1'b1, 16'h1000, 16'h2000, 1'b0, 1'b1);
        checkOutput("bp_w1_sum", {16'd0, out_sum}, 32'h0300);
        applyStimulus(1'b1, 16'h1000, 16'h2000, 1'b0, 1'b1);
        checkOutput("bp_w2_sum", {16'd0, out_sum}, 32'h3000);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        checkOutput("bp_drained", {31'd0, out_valid}, 32'd0);

        // Streaming 100 random words
        r0 = results_seen;
        a0 = accepts;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            applyStimulus(1'b1, ra[15:0], rb[15:0], ra[16], 1'b1);
        end
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        checkOutput("stream_accepts", accepts - a0, 32'd100);
        checkOutput("stream_results", results_seen - r0, 32'd100);

        // Reset while two words are buffered
        applyStimulus(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0);
        checkOutput("pre_rst_full", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("mid_rst_sum", {16'd0, out_sum}, 32'd0);
        checkOutput("mid_rst_cout", {31'd0, out_cout}, 32'd0);
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        checkOutput("post_rst_sum", {16'd0, out_sum}, 32'h0100);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        checkOutput("post_rst_alone", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
